// File: rtl/ebike_pid_pkg.sv
// ebike_pid_pkg: shared types and widths for the PID assist sequencer.
//   pid_sched_state_t : per-tick update sequence states
//   DECIM_W/_FAST     : decimation counter width / sim-mode tick width
//   DRV_W, ERR_W      : drive magnitude and error widths
//   slew_next()       : one slew-limited step of a drive magnitude
package ebike_pid_pkg;

  localparam int DECIM_W      = 20;
  localparam int DECIM_W_FAST = 15;
  localparam int DRV_W        = 12;
  localparam int ERR_W        = 13;

  typedef enum logic [2:0] {IDLE, SAMPLE, UPDATE, SETTLE, SLEW} pid_sched_state_t;

  // Move cur toward tgt by at most step. Both directions are evaluated one
  // bit wider than DRV_W so the sum cannot wrap past full scale and the
  // difference cannot wrap below zero (MSB set = negative).
  function automatic logic [DRV_W-1:0] slew_next(input logic [DRV_W-1:0] cur,
                                                 input logic [DRV_W-1:0] tgt,
                                                 input logic [DRV_W-1:0] step);
    logic [DRV_W:0] up;
    logic [DRV_W:0] dn;
    logic [DRV_W-1:0] res;
    up  = {1'b0, cur} + {1'b0, step};
    dn  = {1'b0, cur} - {1'b0, step};
    res = cur;
    if (tgt > cur)
      res = (up > {1'b0, tgt}) ? tgt : up[DRV_W-1:0];
    else if (tgt < cur)
      res = (dn[DRV_W] || (dn[DRV_W-1:0] < tgt)) ? tgt : dn[DRV_W-1:0];
    return res;
  endfunction

endpackage

// File: rtl/decim_timer.sv
// decim_timer: free-running 20-bit decimation counter with a registered tick.
//   clk   in  system clock
//   rst_n in  async active-low reset
//   tick  out one-cycle pulse, the cycle after the low 20 (or 15 with
//             FAST_SIM) counter bits are all ones
module decim_timer
  import ebike_pid_pkg::*;
#(
  parameter int FAST_SIM = 0
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int TW = (FAST_SIM != 0) ? DECIM_W_FAST : DECIM_W;

  logic [DECIM_W-1:0] cnt_q;
  logic               tick_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_q + DECIM_W'(1);
      tick_q <= &cnt_q[TW-1:0];
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/pid_sched.sv
// pid_sched: per-tick sequencer for the PID assist datapath.
//   clk, rst_n    clock, async active-low reset
//   error         signed error, captured once per tick into err_smp
//   pedal_evt     one-cycle pulse per crank cadence edge
//   pid_mag       saturated PID magnitude from the datapath
//   err_smp       held error for the datapath
//   integ_en      one-cycle integrator accumulate strobe
//   d_shift       one-cycle D-history shift strobe
//   not_pedaling  no cadence for PED_TMO ticks; datapath clears integrator
//   drv_mag       slew-limited drive magnitude
//   tick          decimation pulse (observability)
// Sequence per tick: IDLE -> SAMPLE -> UPDATE -> SETTLE -> SLEW -> IDLE.
// Strobes and drv_mag are registered off the next state, so each is visible
// during the state it belongs to (integ_en 2 clks, drv_mag 4 clks after tick).
module pid_sched
  import ebike_pid_pkg::*;
#(
  parameter int FAST_SIM  = 0,
  parameter int SLEW_STEP = 64,
  parameter int PED_TMO   = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [ERR_W-1:0] error,
  input  logic             pedal_evt,
  input  logic [DRV_W-1:0] pid_mag,
  output logic [ERR_W-1:0] err_smp,
  output logic             integ_en,
  output logic             d_shift,
  output logic             not_pedaling,
  output logic [DRV_W-1:0] drv_mag,
  output logic             tick
);

  localparam logic [DRV_W-1:0] STEP = DRV_W'(SLEW_STEP);
  localparam logic [7:0]       TMO  = 8'(PED_TMO);

  logic tick_w;

  decim_timer #(.FAST_SIM(FAST_SIM)) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick_w)
  );

  pid_sched_state_t state_q, state_d;
  logic [ERR_W-1:0] err_smp_q;
  logic             strobe_q;
  logic [DRV_W-1:0] drv_q, drv_d;
  logic [7:0]       ped_cnt_q, ped_cnt_d;
  logic             not_ped_q, not_ped_d;

  // A tick seen outside IDLE is dropped; the running sequence completes.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (tick_w) state_d = SAMPLE;
      SAMPLE:  state_d = UPDATE;
      UPDATE:  state_d = SETTLE;
      SETTLE:  state_d = SLEW;
      SLEW:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Cadence timeout: pedal_evt beats a coincident tick. not_pedaling has its
  // own flop because it must come out of reset asserted while ped_cnt is 0.
  always_comb begin
    ped_cnt_d = ped_cnt_q;
    if (pedal_evt)
      ped_cnt_d = '0;
    else if (tick_w && (ped_cnt_q < TMO))
      ped_cnt_d = ped_cnt_q + 8'd1;
    not_ped_d = not_ped_q;
    if (pedal_evt)
      not_ped_d = 1'b0;
    else if (ped_cnt_d == TMO)
      not_ped_d = 1'b1;
  end

  // not_ped_q (not _d) feeds the target, so a timeout that lands mid-sequence
  // is honoured at that sequence's SLEW.
  always_comb begin
    drv_d = drv_q;
    if (state_d == SLEW)
      drv_d = slew_next(drv_q, not_ped_q ? '0 : pid_mag, STEP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      err_smp_q <= '0;
      strobe_q  <= 1'b0;
      drv_q     <= '0;
      ped_cnt_q <= '0;
      not_ped_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      if (state_q == SAMPLE) err_smp_q <= error;
      strobe_q  <= (state_d == UPDATE);
      drv_q     <= drv_d;
      ped_cnt_q <= ped_cnt_d;
      not_ped_q <= not_ped_d;
    end
  end

  assign err_smp      = err_smp_q;
  assign integ_en     = strobe_q;
  assign d_shift      = strobe_q;
  assign not_pedaling = not_ped_q;
  assign drv_mag      = drv_q;
  assign tick         = tick_w;

endmodule
